// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl: display-side read controller for the 24-bit pixel FIFO.
// Optional PIXEL_HOLD_LAST_EN: repeat the last good pixel on underflow.
module pixel_fetch_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        de_in,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data_rd,
    output logic        fifo_rd_en,
    output logic        fifo_flush,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        de_out,
    output logic        underflow,
    output logic        busy
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        STREAM,
        RECOVER
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          vsync_q;
    logic          frame_start;
    logic          starve;
    logic          bad_frame;
    logic          rd_en;
    logic          flush_req;
    logic          uf_set;
    logic          rd_q;
    logic          fill_q;
    logic [23:0]   fill_pix;
    logic [23:0]   pix_q;
    logic [1:0]    de_d;
    logic [1:0]    hs_d;
    logic [1:0]    vs_d;

    assign frame_start = vsync_in & ~vsync_q;
    assign starve      = de_in & fifo_empty;
    assign bad_frame   = frame_start & ((x_cnt != '0) | (y_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync_in;
        end
    end

    // RECOVER re-enters through the same frame-start test as WAIT_FRAME
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = WAIT_FRAME;
                WAIT_FRAME, RECOVER: begin
                    if (frame_start && !fifo_empty)
                        state_nxt = STREAM;
                    else if (frame_start)
                        state_nxt = WAIT_FRAME;
                end
                STREAM: begin
                    if (starve)
                        state_nxt = RECOVER;
                    else if (bad_frame)
                        state_nxt = WAIT_FRAME;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en     = 1'b0;
        flush_req = 1'b0;
        uf_set    = 1'b0;
        if (state == STREAM)
            rd_en = de_in & ~fifo_empty;
        if (enable) begin
            unique case (state)
                WAIT_FRAME, RECOVER: begin
                    flush_req = frame_start & fifo_empty;
                end
                STREAM: begin
                    flush_req = starve | bad_frame;
                    uf_set    = starve;
                end
                default: begin
                    flush_req = 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en;
    assign fifo_flush = flush_req;
    assign busy       = (state == STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state != STREAM) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (rd_en) begin
            if (x_cnt == XW'(H_ACTIVE - 1)) begin
                x_cnt <= '0;
                if (y_cnt == YW'(V_ACTIVE - 1))
                    y_cnt <= '0;
                else
                    y_cnt <= y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underflow <= 1'b0;
        else if (uf_set)
            underflow <= 1'b1;
    end

`ifdef PIXEL_HOLD_LAST_EN
    logic [23:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= '0;
        else if (rd_q)
            hold_q <= fifo_data_rd;
    end

    assign fill_pix = hold_q;
`else
    assign fill_pix = '0;
`endif

    // Stage 1 marks read/fill slots; stage 2 picks the pixel source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            fill_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            rd_q   <= rd_en;
            fill_q <= ((state == STREAM) || (state == RECOVER))
                      && de_in && !rd_en;
            if (rd_q)
                pix_q <= fifo_data_rd;
            else if (fill_q)
                pix_q <= fill_pix;
            else
                pix_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            de_d <= {de_d[0], de_in};
            hs_d <= {hs_d[0], hsync_in};
            vs_d <= {vs_d[0], vsync_in};
        end
    end

    assign pixel_r   = pix_q[23:16];
    assign pixel_g   = pix_q[15:8];
    assign pixel_b   = pix_q[7:0];
    assign de_out    = de_d[1];
    assign hsync_out = hs_d[1];
    assign vsync_out = vs_d[1];

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// tb_pixel_fetch_ctrl: scoreboard bench for pixel_fetch_ctrl on a 4x2 frame.
// Define PIXEL_HOLD_LAST_EN here too when the DUT is built with it.
module tb_pixel_fetch_ctrl;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        vsync_in;
    logic        hsync_in;
    logic        de_in;
    logic        fifo_empty;
    logic [23:0] fifo_data_rd = '0;
    logic        fifo_rd_en;
    logic        fifo_flush;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;
    logic        vsync_out;
    logic        hsync_out;
    logic        de_out;
    logic        underflow;
    logic        busy;

    pixel_fetch_ctrl #(
        .H_ACTIVE(H),
        .V_ACTIVE(V)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .vsync_in    (vsync_in),
        .hsync_in    (hsync_in),
        .de_in       (de_in),
        .fifo_empty  (fifo_empty),
        .fifo_data_rd(fifo_data_rd),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_flush  (fifo_flush),
        .pixel_r     (pixel_r),
        .pixel_g     (pixel_g),
        .pixel_b     (pixel_b),
        .vsync_out   (vsync_out),
        .hsync_out   (hsync_out),
        .de_out      (de_out),
        .underflow   (underflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [23:0] fq[$];
    logic [23:0] sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int fl_cnt = 0;
    int fl_hi = 0;
    int viol = 0;
    int hist_n = 0;
    logic [1:0] de_h = '0;
    logic [1:0] hs_h = '0;
    logic [1:0] vs_h = '0;
    logic fl_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] pix(input int i);
        return {8'(17 * (i + 1)), 8'(17 * (i + 2)), 8'(17 * (i + 3))};
    endfunction

    // FIFO model: registered read, data valid the cycle after the strobe
    always @(posedge clk)
        if (fifo_rd_en && fq.size() > 0)
            fifo_data_rd <= fq.pop_front();

    always @(negedge clk) begin
        logic [23:0] exp_pix;
        if (!rst_n) begin
            hist_n  = 0;
            fl_prev = 1'b0;
        end else begin
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && (fifo_empty || !de_in)) viol++;
            if (fifo_flush) fl_hi++;
            if (fifo_flush && !fl_prev) fl_cnt++;
            fl_prev = fifo_flush;
            if (hist_n >= 2) begin
                chk("de_dly", de_out, de_h[1]);
                chk("hs_dly", hsync_out, hs_h[1]);
                chk("vs_dly", vsync_out, vs_h[1]);
            end
            de_h = {de_h[0], de_in};
            hs_h = {hs_h[0], hsync_in};
            vs_h = {vs_h[0], vsync_in};
            hist_n++;
            if (de_out) begin
                if (sb.size() > 0) exp_pix = sb.pop_front();
                else exp_pix = 'x;
                chk("pixel", {pixel_r, pixel_g, pixel_b}, exp_pix);
            end else begin
                chk("blank_pix", {pixel_r, pixel_g, pixel_b}, 0);
            end
        end
    end

    task automatic tick(input logic de, input logic hs, input logic vs);
        @(posedge clk);
        #1;
        de_in      = de;
        hsync_in   = hs;
        vsync_in   = vs;
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic drive_frame(input int npix, input logic [23:0] ev[$]);
        int p = 0;
        tick(0, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        for (int l = 0; l < V && p < npix; l++) begin
            tick(0, 1, 0);
            tick(0, 0, 0);
            for (int i = 0; i < H && p < npix; i++) begin
                sb.push_back(ev[p]);
                tick(1, 0, 0);
                p++;
            end
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fq.push_back(pix(i));
    endtask

    initial begin
        logic [23:0] ev[$];
        logic [23:0] zeros[$];
        logic [23:0] fill;
        int r0;
        int f0;
        int h0;
`ifdef PIXEL_HOLD_LAST_EN
        fill = pix(4);
`else
        fill = '0;
`endif
        for (int i = 0; i < 8; i++) zeros.push_back('0);
        rst_n = 1'b0;
        enable = 1'b0;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        de_in = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_pix", {pixel_r, pixel_g, pixel_b}, 0);
        chk("rst_de", de_out, 0);
        rst_n = 1'b1;
        tick(0, 0, 0);
        enable = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);

        r0 = rd_cnt; f0 = fl_cnt; h0 = fl_hi;
        drive_frame(8, zeros);
        chk("empty_flush", fl_cnt - f0, 1);
        chk("empty_flush_w", fl_hi - h0, 1);
        chk("empty_reads", rd_cnt - r0, 0);
        chk("empty_busy", busy, 0);

        ev = {};
        for (int i = 0; i < 8; i++) ev.push_back(pix(i));
        preload(8);
        r0 = rd_cnt; f0 = fl_cnt;
        drive_frame(8, ev);
        chk("norm_reads", rd_cnt - r0, 8);
        chk("norm_flush", fl_cnt - f0, 0);
        chk("norm_uf", underflow, 0);
        chk("norm_busy", busy, 1);

        preload(8);
        r0 = rd_cnt; f0 = fl_cnt;
        drive_frame(6, ev);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("short_reads", rd_cnt - r0, 6);
        chk("short_flush", fl_cnt - f0, 1);
        chk("short_uf", underflow, 0);
        chk("short_busy", busy, 0);
        fq.delete();
        preload(8);
        r0 = rd_cnt; f0 = fl_cnt;
        drive_frame(8, ev);
        chk("after_short_reads", rd_cnt - r0, 8);
        chk("after_short_flush", fl_cnt - f0, 0);

        ev = {};
        for (int i = 0; i < 5; i++) ev.push_back(pix(i));
        for (int i = 0; i < 3; i++) ev.push_back(fill);
        preload(5);
        r0 = rd_cnt; f0 = fl_cnt; h0 = fl_hi;
        drive_frame(8, ev);
        chk("uf_flag", underflow, 1);
        chk("uf_flush", fl_cnt - f0, 1);
        chk("uf_flush_w", fl_hi - h0, 1);
        chk("uf_reads", rd_cnt - r0, 5);
        chk("uf_busy", busy, 0);
        ev = {};
        for (int i = 0; i < 8; i++) ev.push_back(pix(i));
        preload(8);
        r0 = rd_cnt; f0 = fl_cnt;
        drive_frame(8, ev);
        chk("resume_reads", rd_cnt - r0, 8);
        chk("resume_flush", fl_cnt - f0, 0);
        chk("resume_uf", underflow, 1);

        fq.delete();
        preload(8);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(pix(i));
            tick(1, 0, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_uf", underflow, 0);
        chk("arst_pix", {pixel_r, pixel_g, pixel_b}, 0);
        chk("arst_de", de_out, 0);
        chk("arst_hs_vs", {hsync_out, vsync_out}, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = rd_cnt;
        tick(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('0);
            tick(1, 0, 0);
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("post_rst_reads", rd_cnt - r0, 0);

        enable = 1'b0;
        r0 = rd_cnt; f0 = fl_cnt;
        drive_frame(8, zeros);
        drive_frame(8, zeros);
        chk("dis_reads", rd_cnt - r0, 0);
        chk("dis_flush", fl_cnt - f0, 0);
        chk("dis_busy", busy, 0);

        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        chk("rd_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
